// File: rtl/id_ex_stage.sv
// id_ex_stage: WISC ID/EX pipeline register with MEM/WB operand forwarding and load-use stall detection
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rf0,
  input  logic [DW-1:0] id_rf1,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [2:0]    id_ctrl,
  input  logic [3:0]    id_shamt,
  input  logic          id_alu_op,
  input  logic          id_mem_rd,
  input  logic          id_mem_wr,
  input  logic          id_reg_wr,
  input  logic          flush,
  input  logic          ex_hold,
  input  logic          mem_fwd_wr,
  input  logic [RW-1:0] mem_fwd_rd,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_fwd_wr,
  input  logic [RW-1:0] wb_fwd_rd,
  input  logic [DW-1:0] wb_fwd_data,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [DW-1:0] ex_src0,
  output logic [DW-1:0] ex_src1,
  output logic [DW-1:0] ex_store_data,
  output logic [2:0]    ex_ctrl,
  output logic [3:0]    ex_shamt,
  output logic          ex_alu_op,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          ex_reg_wr,
  output logic [RW-1:0] ex_rd
);
  logic [RW-1:0] rs, rt;
  logic [DW-1:0] rs_val, rt_val, imm, cap0, cap1, fwd0, fwd1;
  logic          use_imm, load_use;
  assign load_use = ex_valid & ex_mem_rd & (ex_rd != '0) & id_valid &
                    ((id_rs == ex_rd) | ((id_rt == ex_rd) & (!id_use_imm | id_mem_wr)));
  assign stall_id = !flush & (ex_hold | load_use);
  // WB bypass at capture covers a register written and read in the same cycle
  always_comb begin
    cap0 = (id_rs == '0) ? '0 : (wb_fwd_wr && wb_fwd_rd == id_rs) ? wb_fwd_data : id_rf0;
    cap1 = (id_rt == '0) ? '0 : (wb_fwd_wr && wb_fwd_rd == id_rt) ? wb_fwd_data : id_rf1;
    fwd0 = (rs == '0) ? '0 : (mem_fwd_wr && mem_fwd_rd == rs) ? mem_fwd_data :
           (wb_fwd_wr && wb_fwd_rd == rs) ? wb_fwd_data : rs_val;
    fwd1 = (rt == '0) ? '0 : (mem_fwd_wr && mem_fwd_rd == rt) ? mem_fwd_data :
           (wb_fwd_wr && wb_fwd_rd == rt) ? wb_fwd_data : rt_val;
  end
  assign ex_src0       = fwd0;
  assign ex_src1       = use_imm ? imm : fwd1;
  assign ex_store_data = fwd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_alu_op <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_reg_wr <= 1'b0;
      ex_ctrl   <= '0;
      ex_shamt  <= '0;
      ex_rd     <= '0;
      rs        <= '0;
      rt        <= '0;
      rs_val    <= '0;
      rt_val    <= '0;
      imm       <= '0;
      use_imm   <= 1'b0;
    end else if (flush | (!ex_hold & load_use)) begin
      ex_valid  <= 1'b0;
      ex_alu_op <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_reg_wr <= 1'b0;
    end else if (!ex_hold) begin
      ex_valid  <= id_valid;
      ex_alu_op <= id_valid & id_alu_op;
      ex_mem_rd <= id_valid & id_mem_rd;
      ex_mem_wr <= id_valid & id_mem_wr;
      ex_reg_wr <= id_valid & id_reg_wr;
      ex_ctrl   <= id_ctrl;
      ex_shamt  <= id_shamt;
      ex_rd     <= id_rd;
      rs        <= id_rs;
      rt        <= id_rt;
      rs_val    <= cap0;
      rt_val    <= cap1;
      imm       <= id_imm;
      use_imm   <= id_use_imm;
    end
  end
endmodule
